// File: rtl/pr_bus_arbiter.sv
// Processor bus arbiter: the CPU MEM stage always owns the bus, and a burst DMA master
// fills the cycles with no CPU access. DMA beats are word-aligned and incrementing.
module pr_bus_arbiter #(
    parameter int unsigned AW    = 32,
    parameter int unsigned LEN_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [AW-1:0]    cpu_addr_i,
    input  logic [3:0]       cpu_be_i,
    input  logic [31:0]      cpu_wd_i,
    input  logic             cpu_we_i,
    input  logic             cpu_re_i,
    output logic [31:0]      cpu_rd_o,
    input  logic             dma_req_i,
    input  logic [AW-1:0]    dma_addr_i,
    input  logic [LEN_W-1:0] dma_len_i,
    input  logic             dma_we_i,
    input  logic [31:0]      dma_wd_i,
    input  logic             dma_abort_i,
    output logic             dma_gnt_o,
    output logic             dma_beat_o,
    output logic [31:0]      dma_rd_o,
    output logic             dma_done_o,
    output logic [CNT_W-1:0] dma_wait_o,
    output logic [AW-1:0]    bus_addr_o,
    output logic [3:0]       bus_be_o,
    output logic [31:0]      bus_wd_o,
    output logic             bus_we_o,
    input  logic [31:0]      bus_rd_i
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             cpu_act;
    logic             beat;

    assign cpu_act = cpu_re_i | cpu_we_i;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        we_d    = we_q;
        wait_d  = wait_q;
        beat    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dma_req_i) begin
                    if (dma_len_i != '0) begin
                        addr_d  = {dma_addr_i[AW-1:2], 2'b00};
                        rem_d   = dma_len_i;
                        we_d    = dma_we_i;
                        wait_d  = '0;
                        state_d = StXfer;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StXfer: begin
                if (cpu_act) begin
                    if (wait_q != '1) begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                end else begin
                    beat   = 1'b1;
                    addr_d = addr_q + AW'(4);
                    rem_d  = rem_q - LEN_W'(1);
                end
                // An abort still lets a beat in the same cycle complete.
                if ((beat && rem_q == LEN_W'(1)) || dma_abort_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        bus_addr_o = cpu_addr_i;
        bus_be_o   = cpu_be_i;
        bus_wd_o   = cpu_wd_i;
        bus_we_o   = cpu_we_i;
        if (beat) begin
            bus_addr_o = addr_q;
            bus_be_o   = 4'b1111;
            bus_wd_o   = dma_wd_i;
            bus_we_o   = we_q;
        end
    end

    assign cpu_rd_o   = bus_rd_i;
    assign dma_rd_o   = bus_rd_i;
    assign dma_beat_o = beat;
    assign dma_gnt_o  = (state_q == StXfer);
    assign dma_done_o = (state_q == StDone);
    assign dma_wait_o = wait_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            wait_q  <= wait_d;
        end
    end

endmodule
